// File: rtl/store_buffer_if.sv
// Pipeline store/load request bundle plus the data-RAM port of the store buffer.
// The buffer is the slave; the pipeline/RAM side is the master.
interface store_buffer_if #(
    parameter int A_WIDTH = 32
);
    logic               st_valid;
    logic               st_ready;
    logic [A_WIDTH-1:0] st_addr;
    logic [2:0]         st_bytes;
    logic [31:0]        st_wd;
    logic               ld_req;
    logic [A_WIDTH-1:0] ld_addr;
    logic [2:0]         ld_bytes;
    logic [31:0]        ld_data;
    logic               ld_stall;
    logic [A_WIDTH-1:0] ram_address;
    logic [2:0]         ram_bytes;
    logic               ram_we;
    logic [31:0]        ram_wd;
    logic [31:0]        ram_dout;
    logic               empty;

    modport master (
        output st_valid, st_addr, st_bytes, st_wd,
        output ld_req, ld_addr, ld_bytes, ram_dout,
        input  st_ready, ld_data, ld_stall, empty,
        input  ram_address, ram_bytes, ram_we, ram_wd
    );

    modport slave (
        input  st_valid, st_addr, st_bytes, st_wd,
        input  ld_req, ld_addr, ld_bytes, ram_dout,
        output st_ready, ld_data, ld_stall, empty,
        output ram_address, ram_bytes, ram_we, ram_wd
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores draining to the data RAM.
// Define STORE_BUF_FWD_EN to forward exact-match stores to loads.
module store_buffer #(
    parameter int A_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW1 = A_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [A_WIDTH-1:0] e_addr  [DEPTH];
    logic [2:0]         e_bytes [DEPTH];
    logic [31:0]        e_wd    [DEPTH];
    logic [DEPTH-1:0]   e_vld;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    function automatic logic [2:0] size_of(input logic [2:0] code);
        case (code)
            3'b000, 3'b100: return 3'd1;
            3'b001, 3'b101: return 3'd2;
            3'b010:         return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    logic [2:0]       ld_size;
    logic [AW1-1:0]   l_lo;
    logic [AW1-1:0]   l_hi;
    logic [DEPTH-1:0] ovl;

    // Range compares are one bit wider so ranges never wrap past the top.
    always_comb begin
        ld_size = size_of(bus.ld_bytes);
        l_lo    = {1'b0, bus.ld_addr};
        l_hi    = l_lo + AW1'(ld_size);
        ovl     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ovl[i] = e_vld[i] && (ld_size != 3'd0)
                && ({1'b0, e_addr[i]} < l_hi)
                && (l_lo < ({1'b0, e_addr[i]} + AW1'(size_of(e_bytes[i]))));
        end
    end

    logic        fwd_hit;
    logic [31:0] fwd_data;

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] yng;
    logic [PW-1:0] idx;
    logic [31:0]   fwd_wd;

    // Walk oldest to youngest so the last overlapping hit wins.
    always_comb begin
        yng = head;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (ovl[idx]) yng = idx;
        end
        fwd_hit = (|ovl) && (e_addr[yng] == bus.ld_addr)
            && (size_of(e_bytes[yng]) == ld_size);
        fwd_wd = e_wd[yng];
        case (bus.ld_bytes)
            3'b000:  fwd_data = {{24{fwd_wd[7]}}, fwd_wd[7:0]};
            3'b001:  fwd_data = {{16{fwd_wd[15]}}, fwd_wd[15:0]};
            3'b100:  fwd_data = {24'd0, fwd_wd[7:0]};
            3'b101:  fwd_data = {16'd0, fwd_wd[15:0]};
            default: fwd_data = fwd_wd;
        endcase
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    logic stall;
    logic ld_go;
    logic drain;
    logic st_ok;
    logic push;

    assign stall = bus.ld_req && (|ovl) && !fwd_hit;
    assign ld_go = bus.ld_req && !stall;
    assign drain = (count != '0) && (!bus.ld_req || stall);
    assign st_ok = bus.st_bytes inside {3'b000, 3'b001, 3'b010};
    assign push  = bus.st_valid && bus.st_ready && st_ok;

    assign bus.st_ready = (count != FULL);
    assign bus.empty    = (count == '0);
    assign bus.ld_stall = stall;

    always_comb begin
        bus.ram_address = '0;
        bus.ram_bytes   = 3'b011;
        bus.ram_we      = 1'b0;
        bus.ram_wd      = '0;
        bus.ld_data     = '0;
        unique case (1'b1)
            ld_go: begin
                bus.ram_address = bus.ld_addr;
                bus.ram_bytes   = bus.ld_bytes;
                bus.ld_data     = fwd_hit ? fwd_data : bus.ram_dout;
            end
            drain: begin
                bus.ram_address = e_addr[head];
                bus.ram_bytes   = e_bytes[head];
                bus.ram_we      = 1'b1;
                bus.ram_wd      = e_wd[head];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            e_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_addr[i]  <= '0;
                e_bytes[i] <= '0;
                e_wd[i]    <= '0;
            end
        end else begin
            if (push) begin
                e_addr[tail]  <= bus.st_addr;
                e_bytes[tail] <= bus.st_bytes;
                e_wd[tail]    <= bus.st_wd;
                e_vld[tail]   <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (drain) begin
                e_vld[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(drain);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed RAM model.
// Forwarding expectations follow STORE_BUF_FWD_EN.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    store_buffer_if #(.A_WIDTH(32)) sb ();

    store_buffer #(.A_WIDTH(32), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb.slave)
    );

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic [7:0]  mem [4096] = '{default: 8'h00};
    int          wr_cnt = 0;
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = '0;
    logic [31:0] pre_word = '0;
    int          n_chk = 0;
    int          n_err = 0;

    function automatic logic [11:0] mi(input logic [31:0] a, input int k);
        return 12'(a + 32'(k));
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem[mi(a, 3)], mem[mi(a, 2)], mem[mi(a, 1)], mem[mi(a, 0)]};
    endfunction

    assign sb.ram_dout = rd_word(sb.ram_address);

    // RAM model: little-endian byte/half/word writes.
    always @(posedge clk) begin
        if (sb.ram_we) begin
            wr_cnt <= wr_cnt + 1;
            mem[mi(sb.ram_address, 0)] <= sb.ram_wd[7:0];
            if (sb.ram_bytes == 3'b001 || sb.ram_bytes == 3'b010)
                mem[mi(sb.ram_address, 1)] <= sb.ram_wd[15:8];
            if (sb.ram_bytes == 3'b010) begin
                mem[mi(sb.ram_address, 2)] <= sb.ram_wd[23:16];
                mem[mi(sb.ram_address, 3)] <= sb.ram_wd[31:24];
            end
        end
        if (pre_en) begin
            mem[mi(pre_addr, 0)] <= pre_word[7:0];
            mem[mi(pre_addr, 1)] <= pre_word[15:8];
            mem[mi(pre_addr, 2)] <= pre_word[23:16];
            mem[mi(pre_addr, 3)] <= pre_word[31:24];
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_st(input logic v, input logic [31:0] a, input logic [2:0] b, input logic [31:0] d);
        sb.st_valid = v;
        sb.st_addr  = a;
        sb.st_bytes = b;
        sb.st_wd    = d;
    endtask

    task automatic set_ld(input logic r, input logic [31:0] a, input logic [2:0] b);
        sb.ld_req   = r;
        sb.ld_addr  = a;
        sb.ld_bytes = b;
    endtask

    task automatic do_reset();
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b0, '0, 3'b000);
        rst_n = 1'b0;
        smp();
        smp();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_word = w;
        tick();
        pre_en   = 1'b0;
    endtask

    typedef struct {
        logic [31:0] sa;
        logic [2:0]  sbt;
        logic [31:0] swd;
        logic [31:0] la;
        logic [2:0]  lbt;
        logic        stall;
        logic        fwd;
        logic [31:0] fdata;
    } vec_t;

    vec_t        vt [13];
    logic        exp_st;
    logic [31:0] exp_d;
    int          base;

    initial begin
        vt[0]  = '{32'h100, 3'b010, 32'h11223344, 32'h100, 3'b010, 1'b1, 1'b1, 32'h11223344};
        vt[1]  = '{32'h100, 3'b010, 32'h11223344, 32'h104, 3'b010, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{32'h100, 3'b010, 32'h11223344, 32'h0FF, 3'b100, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{32'h100, 3'b010, 32'h11223344, 32'h103, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{32'h103, 3'b000, 32'h00000080, 32'h100, 3'b010, 1'b1, 1'b0, 32'h0};
        vt[5]  = '{32'h102, 3'b001, 32'h0000BEEF, 32'h101, 3'b001, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{32'h102, 3'b001, 32'h0000BEEF, 32'h104, 3'b100, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{32'h100, 3'b010, 32'h11223344, 32'h100, 3'b011, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{32'h105, 3'b000, 32'h000000AB, 32'h104, 3'b101, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{32'h000, 3'b000, 32'h00000077, 32'hFFFFFFFE, 3'b010, 1'b0, 1'b0, 32'h0};
        vt[10] = '{32'hFFFFFFFF, 3'b000, 32'h0000005A, 32'hFFFFFFFC, 3'b010, 1'b1, 1'b0, 32'h0};
        vt[11] = '{32'h020, 3'b001, 32'h0000F00D, 32'h020, 3'b101, 1'b1, 1'b1, 32'h0000F00D};
        vt[12] = '{32'h030, 3'b000, 32'h000000FE, 32'h030, 3'b000, 1'b1, 1'b1, 32'hFFFFFFFE};

        // Reset values, then fill four entries behind a non-overlapping load.
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b0, '0, 3'b000);
        rst_n = 1'b0;
        smp();
        chk1("rst empty", sb.empty, 1'b1);
        chk1("rst st_ready", sb.st_ready, 1'b1);
        chk1("rst ram_we", sb.ram_we, 1'b0);
        chk1("rst ld_stall", sb.ld_stall, 1'b0);
        rst_n = 1'b1;
        tick();
        set_ld(1'b1, 32'h800, 3'b010);
        for (int k = 0; k < 4; k++) begin
            set_st(1'b1, 32'h40 + 32'(4 * k), 3'b010, 32'hA0000000 + 32'(k));
            smp();
            chk1($sformatf("fill%0d st_ready", k), sb.st_ready, 1'b1);
            chk1($sformatf("fill%0d ram_we", k), sb.ram_we, 1'b0);
            tick();
        end
        set_st(1'b1, 32'h50, 3'b010, 32'h00000BAD);
        smp();
        chk1("full st_ready", sb.st_ready, 1'b0);
        chk1("full empty", sb.empty, 1'b0);
        tick();
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b0, '0, 3'b000);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk1($sformatf("drain%0d ram_we", k), sb.ram_we, 1'b1);
            chk32($sformatf("drain%0d addr", k), sb.ram_address, 32'h40 + 32'(4 * k));
            chk32($sformatf("drain%0d wd", k), sb.ram_wd, 32'hA0000000 + 32'(k));
            tick();
        end
        smp();
        chk1("drained empty", sb.empty, 1'b1);
        chk1("drained ram_we", sb.ram_we, 1'b0);
        chk32("mem 0x4c", rd_word(32'h4C), 32'hA0000003);
        chk32("mem 0x50 untouched", rd_word(32'h50), 32'h0);

        // Overlap/forwarding table.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            set_st(1'b1, vt[i].sa, vt[i].sbt, vt[i].swd);
            smp();
            chk1($sformatf("v%0d push ram_we", i), sb.ram_we, 1'b0);
            tick();
            set_st(1'b0, '0, 3'b000, '0);
            set_ld(1'b1, vt[i].la, vt[i].lbt);
            smp();
            exp_st = vt[i].stall && !(FWD_ON && vt[i].fwd);
            if (exp_st) exp_d = 32'h0;
            else if (FWD_ON && vt[i].fwd) exp_d = vt[i].fdata;
            else exp_d = rd_word(vt[i].la);
            chk1($sformatf("v%0d ld_stall", i), sb.ld_stall, exp_st);
            chk1($sformatf("v%0d ram_we", i), sb.ram_we, exp_st);
            chk32($sformatf("v%0d ld_data", i), sb.ld_data, exp_d);
            tick();
            set_ld(1'b0, '0, 3'b000);
            tick();
            tick();
        end

        // Unrelated load proceeds while a store waits.
        do_reset();
        preload(32'h200, 32'h12345678);
        set_st(1'b1, 32'h100, 3'b010, 32'hDEADBEEF);
        tick();
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b1, 32'h200, 3'b010);
        smp();
        chk1("ld200 stall", sb.ld_stall, 1'b0);
        chk32("ld200 data", sb.ld_data, 32'h12345678);
        chk1("ld200 ram_we", sb.ram_we, 1'b0);
        chk32("ld200 addr", sb.ram_address, 32'h200);
        tick();
        set_ld(1'b0, '0, 3'b000);
        smp();
        chk1("deferred empty", sb.empty, 1'b0);
        chk1("deferred ram_we", sb.ram_we, 1'b1);
        tick();
        smp();
        chk1("sw drained", sb.empty, 1'b1);
        chk32("mem 0x100", rd_word(32'h100), 32'hDEADBEEF);

        // Byte store blocks a word load until it has drained.
        do_reset();
        preload(32'h100, 32'h0);
        set_st(1'b1, 32'h103, 3'b000, 32'h00000080);
        tick();
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b1, 32'h100, 3'b010);
        smp();
        chk1("sb stall", sb.ld_stall, 1'b1);
        chk32("sb stall data", sb.ld_data, 32'h0);
        chk1("sb ram_we", sb.ram_we, 1'b1);
        chk32("sb addr", sb.ram_address, 32'h103);
        chk32("sb bytes", 32'(sb.ram_bytes), 32'h0);
        chk32("sb wd", sb.ram_wd & 32'hFF, 32'h80);
        tick();
        smp();
        chk1("sb after stall", sb.ld_stall, 1'b0);
        chk32("sb after data", sb.ld_data, 32'h80000000);
        chk1("sb after empty", sb.empty, 1'b1);
        set_ld(1'b0, '0, 3'b000);

        // Half store followed by same-address half loads.
        do_reset();
        set_st(1'b1, 32'h10, 3'b001, 32'h00008001);
        tick();
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b1, 32'h10, 3'b001);
        smp();
`ifdef STORE_BUF_FWD_EN
        chk1("lh fwd stall", sb.ld_stall, 1'b0);
        chk32("lh fwd data", sb.ld_data, 32'hFFFF8001);
        chk1("lh fwd ram_we", sb.ram_we, 1'b0);
        tick();
        set_ld(1'b1, 32'h10, 3'b101);
        smp();
        chk1("lhu fwd stall", sb.ld_stall, 1'b0);
        chk32("lhu fwd data", sb.ld_data, 32'h00008001);
`else
        chk1("lh stall", sb.ld_stall, 1'b1);
        chk32("lh data", sb.ld_data, 32'h0);
        chk1("lh ram_we", sb.ram_we, 1'b1);
`endif
        tick();
        set_ld(1'b0, '0, 3'b000);
        tick();
        tick();

        // Invalid size codes are accepted but not queued.
        do_reset();
        base = wr_cnt;
        set_st(1'b1, 32'h60, 3'b111, 32'h00001234);
        smp();
        chk1("bad111 st_ready", sb.st_ready, 1'b1);
        tick();
        set_st(1'b1, 32'h64, 3'b011, 32'h00005678);
        smp();
        chk1("bad111 empty", sb.empty, 1'b1);
        tick();
        set_st(1'b0, '0, 3'b000, '0);
        smp();
        chk1("bad011 empty", sb.empty, 1'b1);
        chk1("bad ram_we", sb.ram_we, 1'b0);
        tick();
        chk32("bad writes", 32'(wr_cnt - base), 32'h0);

        // Reset pulse in the middle of a drain discards everything.
        do_reset();
        set_ld(1'b1, 32'h800, 3'b010);
        for (int k = 0; k < 3; k++) begin
            set_st(1'b1, 32'h300 + 32'(4 * k), 3'b010, 32'hC0DE0000 + 32'(k));
            tick();
        end
        set_st(1'b0, '0, 3'b000, '0);
        set_ld(1'b0, '0, 3'b000);
        base = wr_cnt;
        smp();
        chk1("mid ram_we", sb.ram_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("mid rst ram_we", sb.ram_we, 1'b0);
        chk1("mid rst empty", sb.empty, 1'b1);
        chk1("mid rst st_ready", sb.st_ready, 1'b1);
        chk1("mid rst ld_stall", sb.ld_stall, 1'b0);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk32("mid rst writes", 32'(wr_cnt - base), 32'h0);
        chk32("mid rst mem 0x300", rd_word(32'h300), 32'h0);
        chk32("mid rst mem 0x308", rd_word(32'h308), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
